// File: rtl/icache_if.sv
// Datapath and memory-side signals of the instruction cache.
// The cache binds to the slave modport; the fetch unit / memory side binds to master.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a two-state refill FSM
// and saturating hit/miss performance counters.
module icache #(
  parameter int SETS = 16
) (
  input  logic     CLK,
  input  logic     RST,
  icache_if.slave  bus
);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 30 - IDXW;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t            r_state;
  logic [SETS-1:0]   r_valid;
  logic [TAGW-1:0]   r_tag  [SETS];
  logic [31:0]       r_data [SETS];
  logic [31:0]       r_miss_addr;
  logic [31:0]       r_hit_count;
  logic [31:0]       r_miss_count;

  logic [IDXW-1:0]   w_idx;
  logic [TAGW-1:0]   w_tag;
  logic [IDXW-1:0]   w_fill_idx;
  logic [TAGW-1:0]   w_fill_tag;
  logic              w_hit;
  logic              w_miss;
  logic              w_fill_we;
  logic              w_fetching;
  logic              w_unused_offset;

  assign w_idx           = bus.imemaddr[2 +: IDXW];
  assign w_tag           = bus.imemaddr[31 -: TAGW];
  assign w_fill_idx      = r_miss_addr[2 +: IDXW];
  assign w_fill_tag      = r_miss_addr[31 -: TAGW];
  assign w_unused_offset = &{1'b0, bus.imemaddr[1:0]};

  // Lookup is only honoured in IDLE; flush and reset both mask a would-be hit.
  assign w_hit = ~RST & (r_state == IDLE) & bus.imemREN & ~bus.flush
               & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss     = (r_state == IDLE) & bus.imemREN & ~bus.flush & ~w_hit;
  assign w_fetching = ~RST & (r_state == FETCH);
  assign w_fill_we  = w_fetching & ~bus.flush & ~bus.iwait;

  assign bus.ihit       = w_hit;
  assign bus.imemload   = w_hit ? r_data[w_idx] : 32'd0;
  assign bus.iREN       = w_fetching;
  assign bus.iaddr      = w_fetching ? r_miss_addr : 32'd0;
  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;

  // Refill FSM, valid bits and counters; flush is applied last so it beats a same-edge fill.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_miss_addr  <= 32'd0;
      r_hit_count  <= 32'd0;
      r_miss_count <= 32'd0;
    end else begin
      if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_state     <= FETCH;
            r_miss_addr <= bus.imemaddr;
            if (r_miss_count != 32'hFFFF_FFFF) begin
              r_miss_count <= r_miss_count + 32'd1;
            end
          end
        end
        FETCH: begin
          if (bus.flush) begin
            r_state <= IDLE;
          end else if (!bus.iwait) begin
            r_state             <= IDLE;
            r_valid[w_fill_idx] <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (bus.flush) begin
        r_valid <= '0;
      end
    end
  end

  // Tag/data payload needs no reset: it is only visible behind a valid bit.
  always_ff @(posedge CLK) begin
    if (w_fill_we) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= bus.iload;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a word-address line model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_icache;
  localparam int SETS = 16;

  logic CLK = 1'b0;
  logic RST;
  icache_if bus();

  icache #(.SETS(SETS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Model: each set remembers the full word address it holds.
  int unsigned m_line [int];
  logic [31:0] m_word [int];
  bit          m_fetch     = 1'b0;
  logic [31:0] m_miss_addr = 32'd0;
  logic [31:0] m_hits      = 32'd0;
  logic [31:0] m_misses    = 32'd0;

  logic        s_ihit, s_iren;
  logic [31:0] s_load, s_iaddr, s_hc, s_mc;

  function automatic int idx_of(logic [31:0] a);
    return int'(a >> 2) % SETS;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a == 32'h0000_0040) ? 32'h8C22_0004 : (a ^ 32'h5A5A_0003);
  endfunction

  function automatic bit model_hit();
    int i;
    i = idx_of(bus.imemaddr);
    return !RST && !m_fetch && bus.imemREN && !bus.flush &&
           m_line.exists(i) && (m_line[i] == (bus.imemaddr >> 2));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: drive, compare against the model mid-cycle, advance the model on the edge.
  task automatic cyc(bit rst, bit ren, logic [31:0] addr, bit fl, bit wt);
    bit          eh;
    logic [31:0] el;
    RST          = rst;
    bus.imemREN  = ren;
    bus.imemaddr = addr;
    bus.flush    = fl;
    bus.iwait    = wt;
    bus.iload    = mem_word(m_fetch ? m_miss_addr : addr);
    @(negedge CLK);
    eh = model_hit();
    el = eh ? m_word[idx_of(addr)] : 32'd0;
    s_ihit = bus.ihit;   s_load = bus.imemload; s_iren = bus.iREN;
    s_iaddr = bus.iaddr; s_hc = bus.hit_count;  s_mc = bus.miss_count;
    chk("model_ihit",     {31'd0, s_ihit}, {31'd0, eh});
    chk("model_imemload", s_load, el);
    chk("model_iREN",     {31'd0, s_iren}, {31'd0, (!RST && m_fetch)});
    chk("model_iaddr",    s_iaddr, (!RST && m_fetch) ? m_miss_addr : 32'd0);
    chk("model_hit_cnt",  s_hc, m_hits);
    chk("model_miss_cnt", s_mc, m_misses);
    @(posedge CLK);
    if (RST) begin
      m_line.delete(); m_word.delete();
      m_fetch = 1'b0; m_miss_addr = 32'd0; m_hits = 32'd0; m_misses = 32'd0;
    end else begin
      if (eh && m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 32'd1;
      if (!m_fetch) begin
        if (bus.imemREN && !bus.flush && !eh) begin
          m_fetch = 1'b1;
          m_miss_addr = bus.imemaddr;
          if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 32'd1;
        end
      end else if (bus.flush) begin
        m_fetch = 1'b0;
      end else if (!bus.iwait) begin
        m_line[idx_of(m_miss_addr)] = m_miss_addr >> 2;
        m_word[idx_of(m_miss_addr)] = bus.iload;
        m_fetch = 1'b0;
      end
      if (bus.flush) begin
        m_line.delete(); m_word.delete();
      end
    end
    #1;
  endtask

  // Miss on addr, zero-wait fill, then the hit cycle.
  task automatic fill(logic [31:0] addr);
    cyc(1'b0, 1'b1, addr, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, addr, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, addr, 1'b0, 1'b0);
    chk("fill_hit", {31'd0, s_ihit}, 32'd1);
  endtask

  initial begin
    int n;
    RST = 1'b1; bus.imemREN = 1'b0; bus.imemaddr = 32'd0;
    bus.flush = 1'b0; bus.iwait = 1'b0; bus.iload = 32'd0;
    repeat (2) @(posedge CLK);
    #1;

    // Outputs quiet while reset is held, even with a request pending.
    cyc(1'b1, 1'b1, 32'h40, 1'b0, 1'b1);
    chk("rst_ihit", {31'd0, s_ihit}, 32'd0);
    chk("rst_iREN", {31'd0, s_iren}, 32'd0);
    chk("rst_iaddr", s_iaddr, 32'd0);
    chk("rst_imemload", s_load, 32'd0);
    chk("rst_hit_cnt", s_hc, 32'd0);

    // Cold miss with two wait cycles.
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
    chk("cold_req_ihit", {31'd0, s_ihit}, 32'd0);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 32'h40, 1'b0, (k < 2) ? 1'b1 : 1'b0);
      if (s_iren && s_iaddr == 32'h40 && !s_ihit) n++;
    end
    chk("cold_fetch_cycles", n, 32'd3);
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    chk("cold_hit", {31'd0, s_ihit}, 32'd1);
    chk("cold_load", s_load, 32'h8C22_0004);
    chk("cold_miss_cnt", s_mc, 32'd1);

    // Four more hits.
    n = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
      if (s_ihit && !s_iren) n++;
    end
    chk("repeat_hits", n, 32'd4);
    cyc(1'b0, 1'b0, 32'h40, 1'b0, 1'b0);
    chk("repeat_hit_cnt", s_hc, 32'd5);

    // Conflict at index 0.
    cyc(1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
    chk("conf_miss", {31'd0, s_ihit}, 32'd0);
    cyc(1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
    chk("conf_iaddr", s_iaddr, 32'h80);
    cyc(1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
    chk("conf_load", s_load, 32'h5A5A_0083);
    fill(32'h40);
    chk("conf_miss_cnt", s_mc, 32'd3);

    // Flush in IDLE masks the hit, later request misses.
    cyc(1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
    chk("flush_mask", {31'd0, s_ihit}, 32'd0);
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    chk("flush_then_miss", {31'd0, s_ihit}, 32'd0);
    // Flush on the completing fetch edge: no line written.
    cyc(1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
    chk("flush_fetch_iREN", {31'd0, s_iren}, 32'd1);
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    chk("flush_abort_idle", {31'd0, s_iren}, 32'd0);
    chk("flush_abort_miss", {31'd0, s_ihit}, 32'd0);
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    chk("flush_refill_hit", {31'd0, s_ihit}, 32'd1);
    chk("flush_miss_cnt", s_mc, 32'd5);

    // Reset during a fill.
    cyc(1'b0, 1'b1, 32'hC0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'hC0, 1'b0, 1'b1);
    chk("rmid_fetch", {31'd0, s_iren}, 32'd1);
    cyc(1'b1, 1'b1, 32'hC0, 1'b0, 1'b0);
    chk("rmid_iREN_in_rst", {31'd0, s_iren}, 32'd0);
    cyc(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0);
    chk("rmid_iREN_after", {31'd0, s_iren}, 32'd0);
    chk("rmid_hit_cnt", s_hc, 32'd0);
    chk("rmid_miss_cnt", s_mc, 32'd0);
    chk("rmid_miss", {31'd0, s_ihit}, 32'd0);
    cyc(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0);
    chk("rmid_refill_hit", {31'd0, s_ihit}, 32'd1);

    // Hit counter saturation.
    force dut.r_hit_count = 32'hFFFF_FFFE;
    m_hits = 32'hFFFF_FFFE;
    #1;
    release dut.r_hit_count;
    cyc(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0);
    chk("sat_preset", s_hc, 32'hFFFF_FFFE);
    cyc(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0);
    chk("sat_max", s_hc, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'hC0, 1'b0, 1'b0);
    chk("sat_no_wrap", s_hc, 32'hFFFF_FFFF);

    // Top index and high tag bits.
    fill(32'hFFFF_FFFC);
    chk("high_load", s_load, 32'hA5A5_FFFF);
    cyc(1'b0, 1'b1, 32'h7FFF_FFFC, 1'b0, 1'b0);
    chk("high_tag_miss", {31'd0, s_ihit}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h7FFF_FFFC, 1'b0, 1'b0);
    chk("high_tag_refill", s_load, 32'h25A5_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter SETS, default 16, giving the number of direct-mapped one-word lines (power of two, 2..256).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, synchronous active-high reset, sampled on the CLK rising edge.
REQ-004 The block SHALL have port imemREN, input, 1, datapath instruction read request.
REQ-005 The block SHALL have port imemaddr, input, 32, datapath fetch address (PC), word aligned.
REQ-006 The block SHALL have port flush, input, 1, invalidate all lines.
REQ-007 The block SHALL have port ihit, output, 1, the requested word is on imemload this cycle.
REQ-008 The block SHALL have port imemload, output, 32, instruction word returned to the datapath.
REQ-009 The block SHALL have port iREN, output, 1, memory-side read request.
REQ-010 The block SHALL have port iaddr, output, 32, memory-side read address.
REQ-011 The block SHALL have port iwait, input, 1, memory busy; a read completes in the first cycle iREN=1 and iwait=0.
REQ-012 The block SHALL have port iload, input, 32, memory read data, valid when iREN=1 and iwait=0.
REQ-013 The block SHALL have ports hit_count and miss_count, output, 32 each, performance counters.

Function
REQ-014 Address split: offset = imemaddr[1:0] (ignored), index = imemaddr[2+log2(SETS)-1:2], tag = the remaining upper bits.
REQ-015 Per line storage: valid bit, tag, 32-bit data.
REQ-016 State machine states: IDLE and FETCH.
REQ-017 In IDLE, ihit = imemREN & valid[index] & tag match, combinationally in the same cycle; imemload = data[index] when ihit=1, else 0.
REQ-018 In IDLE, imemREN=1 with no hit and flush=0 SHALL latch imemaddr into miss_addr and move to FETCH on the next edge.
REQ-019 In FETCH, the block SHALL drive iREN=1 and iaddr=miss_addr and hold ihit=0; iREN=0 and iaddr=0 in IDLE.
REQ-020 In FETCH with iwait=0: the line at miss_addr's index SHALL be written with valid=1, its tag, and data=iload, and the state SHALL return to IDLE; hit in the following cycle if imemaddr still equals miss_addr.
REQ-021 Miss latency: request cycle (IDLE) + at least one FETCH cycle + hit cycle; with iwait=0 throughout, ihit rises on the 3rd cycle of the request.
REQ-022 Changes to imemREN or imemaddr during FETCH SHALL NOT abort the fill; the fill completes for miss_addr.
REQ-023 flush=1 SHALL clear every valid bit on that edge; in FETCH it also aborts to IDLE with no line write; in IDLE ihit SHALL be forced to 0 that cycle.
REQ-024 A fill replaces the line at the indexed set unconditionally, including a valid line with a different tag.
REQ-025 hit_count SHALL increment on every edge where ihit=1; miss_count SHALL increment on every IDLE->FETCH transition; both saturate at 32'hFFFFFFFF.
REQ-026 Same-edge fill and flush: flush wins, so no line becomes valid.

Reset
REQ-027 RST=1 SHALL, on the edge, clear all valid bits, set the state to IDLE, clear miss_addr and both counters; RST has priority over flush and fill.
REQ-028 While RST=1, outputs SHALL be ihit=0, iREN=0, iaddr=0, imemload=0; tag and data arrays need no reset.
REQ-029 RST asserted during FETCH SHALL drop iREN on the next edge and discard the pending fill.

Verification
REQ-030 Cold miss: imemREN=1, imemaddr=0x00000040, iwait=1 for 2 cycles then 0, iload=0x8C220004 -> iREN=1 with iaddr=0x40 for 3 cycles, then ihit=1 with imemload=0x8C220004; miss_count=1, hit_count=1.
REQ-031 Repeat hit: after REQ-030, 4 cycles requesting 0x40 -> ihit=1 every cycle, iREN=0, hit_count=5.
REQ-032 Conflict: with SETS=16, fill 0x40, then request 0x80 (same index 0) -> miss and refill; a subsequent request to 0x40 misses again; miss_count=3.
REQ-033 Flush: after fill of 0x40, pulse flush one cycle -> request to 0x40 misses; flush during FETCH with iwait=0 -> line stays invalid, state IDLE.
REQ-034 Reset mid-fill: RST=1 in FETCH -> iREN=0 next cycle, counters 0, following request to the same address misses.
REQ-035 Saturation: preload hit_count to 32'hFFFFFFFE (force), two hit cycles -> hit_count=32'hFFFFFFFF, no wrap.
